// File: rtl/clk_mon_pkg.sv
// Shared state encoding and widths for clk_div_monitor and related clock checkers.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } mon_state_t;

  localparam int unsigned ERR_CNT_W = 8;

  function automatic logic [ERR_CNT_W-1:0] err_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus history flop; flags the first synchronized cycle of a rising edge.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures the divided clock clk_in against clk: period, lock, error count and loss-of-clock.
// Optional high-time measurement enabled by defining CLK_MON_DUTY_EN.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned EXP_PERIOD = 2,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_in,
  output logic [CNT_W-1:0]     period_o,
  output logic [CNT_W-1:0]     high_o,
  output logic                 valid_o,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 timeout_o
);

  localparam int unsigned        MATCH_W    = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]     EXP_C      = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]     TOL_C      = (CNT_W+1)'(TOL);
  localparam logic [MATCH_W-1:0] LOCK_C     = MATCH_W'(LOCK_CNT);

  logic level, rise;

  sync_edge u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (clk_in),
    .level (level),
    .rise  (rise)
  );

  mon_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [MATCH_W-1:0] match_cnt, match_next;
  logic [CNT_W:0]     cnt_x, diff;
  logic               in_tol, timeout_hit;

  // A rise on the cycle cnt would reach TIMEOUT takes priority over the timeout.
  always_comb begin
    cnt_x       = {1'b0, cnt};
    diff        = (cnt_x >= EXP_C) ? (cnt_x - EXP_C) : (EXP_C - cnt_x);
    in_tol      = (diff <= TOL_C);
    match_next  = match_cnt + 1'b1;
    timeout_hit = !rise && (state != LOST) && (cnt >= TIMEOUT_M1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (cnt != TIMEOUT_C) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      match_cnt <= '0;
      period_o  <= '0;
      valid_o   <= 1'b0;
      locked_o  <= 1'b0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
      timeout_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      if (timeout_hit) begin
        state     <= LOST;
        timeout_o <= 1'b1;
        locked_o  <= 1'b0;
        match_cnt <= '0;
      end else if (rise) begin
        case (state)
          IDLE: state <= MEASURE;
          MEASURE: begin
            period_o <= cnt;
            valid_o  <= 1'b1;
            if (!in_tol) begin
              match_cnt <= '0;
            end else if (match_next == LOCK_C) begin
              match_cnt <= '0;
              state     <= LOCKED;
              locked_o  <= 1'b1;
            end else begin
              match_cnt <= match_next;
            end
          end
          LOCKED: begin
            period_o <= cnt;
            valid_o  <= 1'b1;
            if (!in_tol) begin
              err_o     <= 1'b1;
              err_cnt_o <= err_inc(err_cnt_o);
              locked_o  <= 1'b0;
              match_cnt <= '0;
              state     <= MEASURE;
            end
          end
          LOST: begin
            state     <= MEASURE;
            timeout_o <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CLK_MON_DUTY_EN
  logic [CNT_W-1:0] hcnt;

  // The rise cycle itself is the first high cycle of the new period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt   <= '0;
      high_o <= '0;
    end else begin
      if (rise) begin
        hcnt <= CNT_W'(1);
      end else if (level && (hcnt != TIMEOUT_C)) begin
        hcnt <= hcnt + 1'b1;
      end
      if (rise && ((state == MEASURE) || (state == LOCKED))) begin
        high_o <= hcnt;
      end
    end
  end
`else
  logic level_unused;
  assign level_unused = level;
  assign high_o       = '0;
`endif

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: a period-level model predicts each valid_o result.
module tb_clk_div_monitor;
  import clk_mon_pkg::*;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned EXP_PERIOD = 2;
  localparam int unsigned TOL        = 0;
  localparam int unsigned LOCK_CNT   = 4;
  localparam int unsigned TIMEOUT    = 1024;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 clk_in;
  logic [CNT_W-1:0]     period_o, high_o;
  logic                 valid_o, locked_o, err_o, timeout_o;
  logic [ERR_CNT_W-1:0] err_cnt_o;

  always #5 clk = ~clk;

  clk_div_monitor #(
    .CNT_W      (CNT_W),
    .EXP_PERIOD (EXP_PERIOD),
    .TOL        (TOL),
    .LOCK_CNT   (LOCK_CNT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_in    (clk_in),
    .period_o  (period_o),
    .high_o    (high_o),
    .valid_o   (valid_o),
    .locked_o  (locked_o),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o),
    .timeout_o (timeout_o)
  );

  typedef struct {
    int unsigned period;
    int unsigned high;
    bit          locked;
    bit          err;
    int unsigned errs;
  } exp_t;

  exp_t        sb[$];
  exp_t        want;
  int unsigned tests = 0;
  int unsigned fails = 0;

  mon_state_t  m_state = IDLE;
  int unsigned m_match = 0;
  int unsigned m_errs  = 0;
  int unsigned m_since = 0;
  int unsigned m_high  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want_v);
    tests++;
    if (got !== want_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want_v);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_period"},  32'(period_o),  32'd0);
    check_eq({tag, "_high"},    32'(high_o),    32'd0);
    check_eq({tag, "_valid"},   32'(valid_o),   32'd0);
    check_eq({tag, "_locked"},  32'(locked_o),  32'd0);
    check_eq({tag, "_err"},     32'(err_o),     32'd0);
    check_eq({tag, "_err_cnt"}, 32'(err_cnt_o), 32'd0);
    check_eq({tag, "_timeout"}, 32'(timeout_o), 32'd0);
  endtask

  // Called when the bench drives a clk_in rising edge; m_since is the period just ended.
  task automatic model_rise();
    int unsigned p    = m_since;
    int unsigned dev  = (p >= EXP_PERIOD) ? (p - EXP_PERIOD) : (EXP_PERIOD - p);
    bit          good = (dev <= TOL);
    mon_state_t  prev;
    exp_t        e;
    if ((m_state != LOST) && (p >= TIMEOUT)) begin
      m_state = LOST;
      m_match = 0;
    end
    prev = m_state;
    case (m_state)
      IDLE, LOST: m_state = MEASURE;
      MEASURE: begin
        if (good) m_match++;
        else m_match = 0;
        if (m_match == LOCK_CNT) begin
          m_state = LOCKED;
          m_match = 0;
        end
      end
      default: begin
        if (!good) begin
          m_state = MEASURE;
          m_match = 0;
          if (m_errs < 255) m_errs++;
        end
      end
    endcase
    if ((prev == MEASURE) || (prev == LOCKED)) begin
      e.period = p;
`ifdef CLK_MON_DUTY_EN
      e.high   = m_high;
`else
      e.high   = 0;
`endif
      e.locked = (m_state == LOCKED);
      e.err    = (prev == LOCKED) && !good;
      e.errs   = m_errs;
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    m_since++;
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo);
    model_rise();
    m_since = 0;
    clk_in  = 1'b1;
    repeat (hi) tick();
    clk_in  = 1'b0;
    repeat (lo) tick();
    m_high  = hi;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (valid_o) begin
        check_eq("valid_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          want = sb.pop_front();
          check_eq("period",  32'(period_o),  want.period);
          check_eq("high",    32'(high_o),    want.high);
          check_eq("locked",  32'(locked_o),  32'(want.locked));
          check_eq("err",     32'(err_o),     32'(want.err));
          check_eq("err_cnt", 32'(err_cnt_o), want.errs);
        end
      end else begin
        check_eq("err_without_valid", 32'(err_o), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    clk_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("por");
    reset   = 1'b1;
    m_since = 0;

    // clk/2 input: lock on the fifth rise
    repeat (8) pulse(1, 1);
    check_eq("locked_clk2", 32'(locked_o), 32'd1);
    check_eq("period_clk2", 32'(period_o), 32'd2);

    // one stretched period of 6
    pulse(3, 3);
    repeat (6) pulse(1, 1);
    check_eq("err_cnt_after_stretch", 32'(err_cnt_o), 32'd1);
    check_eq("relock_after_stretch", 32'(locked_o), 32'd1);

    // period 8 with 3 high cycles
    repeat (3) pulse(3, 5);
    repeat (6) pulse(1, 1);
    check_eq("relock_after_duty", 32'(locked_o), 32'd1);

    // period TIMEOUT-1: the rise wins, no timeout
    pulse(1, TIMEOUT - 2);
    repeat (6) pulse(1, 1);
    check_eq("no_timeout_below_limit", 32'(timeout_o), 32'd0);

    // loss of clock: counted from the start of the rise-detect cycle
    pulse(1, 0);
    while (m_since < TIMEOUT + 1) tick();
    check_eq("timeout_before_limit", 32'(timeout_o), 32'd0);
    tick();
    check_eq("timeout_at_limit", 32'(timeout_o), 32'd1);
    check_eq("unlocked_on_timeout", 32'(locked_o), 32'd0);
    repeat (2) pulse(1, 1);
    check_eq("timeout_cleared", 32'(timeout_o), 32'd0);
    repeat (4) pulse(1, 1);
    check_eq("relock_after_lost", 32'(locked_o), 32'd1);

    // asynchronous reset while locked
    repeat (2) tick();
    check_eq("sb_drained_before_reset", sb.size(), 32'd0);
    reset = 1'b0;
    #1;
    check_reset_outputs("async");
    @(posedge clk);
    #2;
    reset   = 1'b1;
    m_state = IDLE;
    m_match = 0;
    m_errs  = 0;
    m_since = 0;
    repeat (6) pulse(1, 1);
    check_eq("locked_after_reset", 32'(locked_o), 32'd1);

    // error counter saturation
    repeat (305) begin
      repeat (4) pulse(1, 1);
      pulse(1, 2);
    end
    repeat (2) pulse(1, 1);
    repeat (2) tick();
    check_eq("err_cnt_saturated", 32'(err_cnt_o), 32'd255);
    check_eq("sb_drained_at_end", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
